// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage, 64-bit counters, trap entry/return and interrupt qualification
module csr_file #(
  parameter logic [31:0] HARTID    = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  output logic [31:0] csr_rdata,
  input  logic        csr_wen,
  input  logic [31:0] csr_wdata,
  output logic        illegal_csr,
  input  logic        instret_inc,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        irq_pending,
  input  logic        irq_ext,
  input  logic        irq_timer
);
  logic        ms_mie, ms_mpie, mtie, meie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;
  logic        impl, ro, we;
  logic [31:0] mstatus_v, mie_v, mip_v;
  assign mstatus_v = {19'd0, 2'b11, 3'd0, ms_mpie, 3'd0, ms_mie, 3'd0};
  assign mie_v     = {20'd0, meie, 3'd0, mtie, 7'd0};
  assign mip_v     = {20'd0, irq_ext, 3'd0, irq_timer, 7'd0};
  always_comb begin
    csr_rdata = '0;
    impl      = 1'b1;
    case (csr_addr)
      12'h300: csr_rdata = mstatus_v;
      12'h304: csr_rdata = mie_v;
      12'h305: csr_rdata = mtvec;
      12'h340: csr_rdata = mscratch;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
      12'h343: csr_rdata = mtval;
      12'h344: csr_rdata = mip_v;
      12'hB00, 12'hC00: csr_rdata = mcycle[31:0];
      12'hB80, 12'hC80: csr_rdata = mcycle[63:32];
      12'hB02, 12'hC02: csr_rdata = minstret[31:0];
      12'hB82, 12'hC82: csr_rdata = minstret[63:32];
      12'hF14: csr_rdata = HARTID;
      default: impl = 1'b0;
    endcase
  end
  assign ro          = (csr_addr[11:10] == 2'b11) || (csr_addr == 12'h344);
  assign illegal_csr = !impl || (csr_wen && ro);
  // traps and mret take the cycle; a concurrent CSR write is lost
  assign we          = csr_wen && !illegal_csr && !trap_valid && !mret;
  assign trap_vector = {mtvec[31:2], 2'b00} +
                       ((mtvec[0] && trap_cause[31]) ? {25'd0, trap_cause[4:0], 2'b00} : 32'd0);
  assign irq_pending = ms_mie & ((irq_ext & meie) | (irq_timer & mtie));
  assign mepc_out    = mepc;
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_mie   <= 1'b0;
      ms_mpie  <= 1'b0;
      mtie     <= 1'b0;
      meie     <= 1'b0;
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap_valid) begin
      mepc    <= trap_pc & ~32'd3;
      mcause  <= trap_cause;
      mtval   <= trap_tval;
      ms_mpie <= ms_mie;
      ms_mie  <= 1'b0;
    end else if (mret) begin
      ms_mie  <= ms_mpie;
      ms_mpie <= 1'b1;
    end else if (we) begin
      case (csr_addr)
        12'h300: begin
          ms_mie  <= csr_wdata[3];
          ms_mpie <= csr_wdata[7];
        end
        12'h304: begin
          mtie <= csr_wdata[7];
          meie <= csr_wdata[11];
        end
        12'h305: mtvec    <= csr_wdata & ~32'd2;
        12'h340: mscratch <= csr_wdata;
        12'h341: mepc     <= csr_wdata & ~32'd3;
        12'h342: mcause   <= csr_wdata;
        12'h343: mtval    <= csr_wdata;
        default: ;
      endcase
    end
  end
  // a write to either counter half replaces that cycle's increment
  always_ff @(posedge clk) begin
    if (rst) mcycle <= '0;
    else if (we && csr_addr == 12'hB00) mcycle[31:0] <= csr_wdata;
    else if (we && csr_addr == 12'hB80) mcycle[63:32] <= csr_wdata;
    else mcycle <= mcycle + 64'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) minstret <= '0;
    else if (we && csr_addr == 12'hB02) minstret[31:0] <= csr_wdata;
    else if (we && csr_addr == 12'hB82) minstret[63:32] <= csr_wdata;
    else if (instret_inc) minstret <= minstret + 64'd1;
  end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed stimulus with a queued-expectation scoreboard for csr_file
module tb_csr_file;
  logic        clk, rst, csr_wen, illegal_csr, instret_inc, trap_valid, mret;
  logic        irq_pending, irq_ext, irq_timer;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, csr_wdata, trap_cause, trap_pc, trap_tval, trap_vector, mepc_out;
  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [31:0] act;
  logic        mon_req;
  int          checks = 0, errors = 0;
  localparam int RD = 0, ILL = 1, TV = 2, EPC = 3, IRQ = 4;

  csr_file #(.HARTID(32'd3), .MTVEC_RST(32'h0000_0040)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_wdata(csr_wdata), .illegal_csr(illegal_csr),
    .instret_inc(instret_inc), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret), .trap_vector(trap_vector),
    .mepc_out(mepc_out), .irq_pending(irq_pending), .irq_ext(irq_ext), .irq_timer(irq_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_req) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        act = e.sel == RD  ? csr_rdata :
              e.sel == ILL ? {31'd0, illegal_csr} :
              e.sel == TV  ? trap_vector :
              e.sel == EPC ? mepc_out : {31'd0, irq_pending};
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int s, input logic [31:0] v, input string n);
    q.push_back('{s, v, n});
  endtask

  task automatic cyc();
    mon_req = 1'b1;
    step();
    mon_req = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_wen   = 1'b1;
    step();
    csr_wen   = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] v, input string n);
    csr_addr = a;
    expect_v(RD, v, n);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    mon_req = 1'b0; rst = 1'b1; csr_wen = 1'b0; instret_inc = 1'b0; trap_valid = 1'b0;
    mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; csr_addr = 12'h0; csr_wdata = '0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    repeat (3) step();
    rst = 1'b0;
    rd(12'hB00, 32'd0, "mcycle_after_reset");
    rd(12'hB00, 32'd1, "mcycle_increment");
    csr_addr = 12'h300;
    expect_v(RD, 32'h0000_1800, "mstatus_reset");
    expect_v(ILL, 32'd0, "mstatus_legal");
    expect_v(IRQ, 32'd0, "irq_reset");
    cyc();
    rd(12'h304, 32'd0, "mie_reset");
    rd(12'h305, 32'h0000_0040, "mtvec_reset");
    rd(12'hF14, 32'd3, "mhartid");
    // mtvec write masking and 1-cycle latency
    csr_addr = 12'h305; csr_wdata = 32'h8000_0107; csr_wen = 1'b1;
    expect_v(ILL, 32'd0, "mtvec_write_legal");
    cyc();
    csr_wen = 1'b0;
    rd(12'h305, 32'h8000_0105, "mtvec_bit1_forced");
    // vectored trap target
    wr(12'h305, 32'h8000_0101);
    trap_cause = 32'h8000_0007;
    expect_v(TV, 32'h8000_011C, "trap_vector_vectored_irq");
    cyc();
    trap_cause = 32'h0000_0002;
    expect_v(TV, 32'h8000_0100, "trap_vector_exception");
    cyc();
    // trap entry and mret
    wr(12'h300, 32'h0000_0008);
    rd(12'h300, 32'h0000_1808, "mstatus_mie_set");
    trap_valid = 1'b1; trap_pc = 32'h0000_1003; trap_cause = 32'h0000_0002; trap_tval = 32'h0000_DEAD;
    step();
    trap_valid = 1'b0;
    csr_addr = 12'h341;
    expect_v(RD, 32'h0000_1000, "mepc_aligned");
    expect_v(EPC, 32'h0000_1000, "mepc_out");
    cyc();
    rd(12'h300, 32'h0000_1880, "mstatus_after_trap");
    rd(12'h342, 32'h0000_0002, "mcause");
    rd(12'h343, 32'h0000_DEAD, "mtval");
    mret = 1'b1;
    step();
    mret = 1'b0;
    rd(12'h300, 32'h0000_1888, "mstatus_after_mret");
    // minstret: write beats increment, then carry into high half
    instret_inc = 1'b1;
    wr(12'hB02, 32'hFFFF_FFFF);
    rd(12'hB02, 32'hFFFF_FFFF, "minstret_write_over_inc");
    instret_inc = 1'b0;
    rd(12'hB02, 32'd0, "minstret_low_wrap");
    rd(12'hB82, 32'd1, "minstreth_carry");
    rd(12'hC82, 32'd1, "instreth_alias");
    // illegal accesses
    csr_addr = 12'hC00; csr_wdata = 32'h0000_0123; csr_wen = 1'b1;
    expect_v(ILL, 32'd1, "write_ro_counter");
    cyc();
    csr_addr = 12'h7C0;
    expect_v(ILL, 32'd1, "write_unimpl");
    cyc();
    csr_addr = 12'h344;
    expect_v(ILL, 32'd1, "write_mip");
    cyc();
    csr_wen = 1'b0;
    csr_addr = 12'h7C0;
    expect_v(RD, 32'd0, "read_unimpl_zero");
    expect_v(ILL, 32'd1, "read_unimpl_illegal");
    cyc();
    rd(12'h305, 32'h8000_0101, "mtvec_unchanged");
    // interrupts
    irq_ext = 1'b1; irq_timer = 1'b1;
    csr_addr = 12'h344;
    expect_v(RD, 32'h0000_0880, "mip_levels");
    expect_v(ILL, 32'd0, "mip_read_legal");
    expect_v(IRQ, 32'd0, "irq_masked_by_mie");
    cyc();
    wr(12'h304, 32'hFFFF_FFFF);
    rd(12'h304, 32'h0000_0880, "mie_mask");
    wr(12'h304, 32'h0000_0800);
    irq_timer = 1'b0;
    expect_v(IRQ, 32'd1, "irq_ext_pending");
    cyc();
    irq_ext = 1'b0; irq_timer = 1'b1;
    expect_v(IRQ, 32'd0, "irq_timer_disabled");
    cyc();
    irq_timer = 1'b0;
    // trap outranks a same-cycle write
    trap_valid = 1'b1; trap_pc = 32'h0000_2007;
    wr(12'h340, 32'h0000_0055);
    trap_valid = 1'b0;
    csr_addr = 12'h340;
    expect_v(RD, 32'd0, "write_dropped_by_trap");
    expect_v(EPC, 32'h0000_2004, "mepc_trap2");
    cyc();
    // 64-bit mcycle wrap
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'hFFFF_FFFF);
    rd(12'hB80, 32'hFFFF_FFFF, "mcycleh_before_wrap");
    rd(12'hB00, 32'd0, "mcycle_wrapped");
    rd(12'hB80, 32'd0, "mcycleh_wrapped");
    // reset overrides a same-cycle trap
    rst = 1'b1; trap_valid = 1'b1; trap_pc = 32'h0000_3000;
    step();
    rst = 1'b0; trap_valid = 1'b0;
    csr_addr = 12'h300;
    expect_v(RD, 32'h0000_1800, "mstatus_mid_reset");
    expect_v(EPC, 32'd0, "mepc_mid_reset");
    cyc();
    rd(12'h305, 32'h0000_0040, "mtvec_mid_reset");
    step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
